// File: rtl/soc_system_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_pio_pkg
//  Description : Register offsets and edge-type encodings shared by the
//                fabric PIO blocks on the lightweight bridge.
//  Revision    : 1.0
// ============================================================================
package soc_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_RESERVED = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage : soc_system_pio_pkg
`default_nettype wire

// File: rtl/soc_system_status_capture_pio_if.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_status_capture_pio_if
//  Description : Avalon-MM slave bus (zero-wait reads) plus level interrupt.
//  Revision    : 1.0
// ============================================================================
interface soc_system_status_capture_pio_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );

endinterface : soc_system_status_capture_pio_if
`default_nettype wire

// File: rtl/soc_system_pio_sync.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_pio_sync
//  Description : WIDTH x SYNC_STAGES flop chain bringing async inputs into clk.
//  Revision    : 1.0
// ============================================================================
module soc_system_pio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_chain [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign q = r_chain[SYNC_STAGES-1];

endmodule : soc_system_pio_sync
`default_nettype wire

// File: rtl/soc_system_status_capture_pio.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_status_capture_pio
//  Description : Input PIO with sticky edge capture, W1C clear and maskable irq.
//  Revision    : 1.0
// ============================================================================
module soc_system_status_capture_pio
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int EDGE_TYPE     = 0,
    parameter int RESET_CAPTURE = 0
) (
    input  wire logic                         clk,
    input  wire logic                         reset_n,
    soc_system_status_capture_pio_if.slave    bus,
    input  wire logic [WIDTH-1:0]             in_port
);

    localparam logic [WIDTH-1:0] C_CAPTURE_INIT = {WIDTH{(RESET_CAPTURE != 0)}};

    logic [WIDTH-1:0] w_sync_data;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_capture;
    logic             r_irq;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_capture_next;
    logic [WIDTH-1:0] w_irq_mask_next;
    logic             w_wr;
    logic [31:0]      w_readdata;

    soc_system_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (w_sync_data)
    );

    generate
        if (EDGE_TYPE == EDGE_FALLING) begin : g_edge_fall
            assign w_edge = ~w_sync_data & r_prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
            assign w_edge = w_sync_data ^ r_prev;
        end else begin : g_edge_rise
            assign w_edge = w_sync_data & ~r_prev;
        end
    endgenerate

    assign w_wr            = bus.chipselect & ~bus.write_n;
    assign w_clr           = (w_wr && bus.address == ADDR_EDGE_CAP) ? bus.writedata[WIDTH-1:0] : '0;
    // Edge is OR'd after the clear so a coincident edge is never lost.
    assign w_capture_next  = (r_capture & ~w_clr) | w_edge;
    assign w_irq_mask_next = (w_wr && bus.address == ADDR_IRQ_MASK) ? bus.writedata[WIDTH-1:0]
                                                                    : r_irq_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev     <= '0;
            r_irq_mask <= '0;
            r_capture  <= C_CAPTURE_INIT;
            r_irq      <= 1'b0;
        end else begin
            r_prev     <= w_sync_data;
            r_irq_mask <= w_irq_mask_next;
            r_capture  <= w_capture_next;
            r_irq      <= |(w_capture_next & w_irq_mask_next);
        end
    end

    always_comb begin
        w_readdata = '0;
        case (bus.address)
            ADDR_DATA:     w_readdata[WIDTH-1:0] = w_sync_data;
            ADDR_IRQ_MASK: w_readdata[WIDTH-1:0] = r_irq_mask;
            ADDR_EDGE_CAP: w_readdata[WIDTH-1:0] = r_capture;
            default:       w_readdata            = '0;
        endcase
    end

    assign bus.readdata = w_readdata;
    assign bus.irq      = r_irq;

endmodule : soc_system_status_capture_pio
`default_nettype wire
